// File: rtl/abus_rr_ctrl.sv
// Registered round-robin bus arbitration controller with bounded ownership and a one-cycle
// turnaround. Define ABUS_RR_LOCK_EN to let the owner's lock input suppress forced release.
module abus_rr_ctrl #(
  parameter int unsigned N        = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 lock,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 preempt
);

  localparam int unsigned IdxW  = $clog2(N);
  localparam int unsigned HoldW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(N - 1);

  typedef enum logic [1:0] {StIdle, StOwn, StGap} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic             valid_q, valid_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [IdxW-1:0]  ptr_q, ptr_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             preempt_q, preempt_d;

  logic             lock_hold;
  logic             owner_req;
  logic             others;
  logic             at_limit;
  logic             win_found;
  logic [IdxW-1:0]  win_idx;

`ifdef ABUS_RR_LOCK_EN
  assign lock_hold = lock;
`else
  logic unused_lock;
  assign unused_lock = lock;
  assign lock_hold   = 1'b0;
`endif

  // Circular priority search starting at ptr_q.
  always_comb begin
    int unsigned     j;
    logic [IdxW-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    cand      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = 32'(ptr_q) + i;
      if (j >= N) j = j - N;
      cand = IdxW'(j);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign owner_req = req[idx_q];
  assign others    = |(req & ~grant_q);
  assign at_limit  = (MAX_HOLD != 0) && (hold_q == HoldMax);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    unique case (state_q)
      StIdle, StGap: begin
        if (win_found) begin
          state_d = StOwn;
          grant_d = N'(1) << win_idx;
          idx_d   = win_idx;
          hold_d  = HoldW'(1);
        end else begin
          state_d = StIdle;
        end
      end
      StOwn: begin
        if (!owner_req || (at_limit && others && !lock_hold)) begin
          state_d   = StGap;
          grant_d   = '0;
          ptr_d     = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
          // Still requesting at release time means the release was forced.
          preempt_d = owner_req;
        end else if (MAX_HOLD != 0 && hold_q != HoldMax) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    valid_d = |grant_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_idx   = idx_q;
  assign preempt     = preempt_q;

endmodule

// File: tb/tb_abus_rr_ctrl.sv
// Self-checking bench for abus_rr_ctrl: directed vector table, hand sequences for rotation and
// lock, and a randomized run against an ownership-level reference model.
module tb_abus_rr_ctrl;

  localparam int unsigned N       = 8;
  localparam int unsigned MaxHold = 4;
`ifdef ABUS_RR_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic         lock;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [2:0]   grant_idx;
  logic         preempt;

  int n_checks = 0;
  int n_errors = 0;

  abus_rr_ctrl #(.N(N), .MAX_HOLD(MaxHold)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .lock        (lock),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .preempt     (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    logic [7:0] req;
    bit         lock;
    logic [7:0] grant;
    bit         preempt;
    logic [2:0] idx;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input logic [7:0] rq, input logic [7:0] g, input bit p,
                     input logic [2:0] i);
    vec_t v;
    v.rst = r; v.req = rq; v.lock = 1'b0; v.grant = g; v.preempt = p; v.idx = i;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] g, input bit p,
                           input logic [2:0] i);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".valid"}, 32'(grant_valid), 32'(|g));
    check({tag, ".preempt"}, 32'(preempt), 32'(p));
    check({tag, ".idx"}, 32'(grant_idx), 32'(i));
  endtask

  // Reference model: tracks who owns the bus and for how long, updated once per edge.
  int m_owner, m_last, m_ptr, m_held;
  bit m_pre;

  task automatic model_edge(input bit r, input logic [N-1:0] rq, input bit lk);
    bit others;
    if (r) begin
      m_owner = -1; m_last = 0; m_ptr = 0; m_held = 0; m_pre = 0;
      return;
    end
    m_pre = 0;
    if (m_owner >= 0) begin
      others = (rq & ~(N'(1) << m_owner)) != 0;
      if (!rq[m_owner]) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
      end else if (MaxHold != 0 && m_held >= MaxHold && others && !(LockEn && lk)) begin
        m_pre = 1;
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end else if (rq != 0) begin
      for (int i = 0; i < N; i++) begin
        if (rq[(m_ptr + i) % N]) begin
          m_owner = (m_ptr + i) % N;
          break;
        end
      end
      m_last = m_owner;
      m_held = 1;
    end
  endtask

  initial begin
    int           cnt[N];
    logic [N-1:0] want;

    rst = 1'b1; req = 8'hFF; lock = 1'b0;

    // Reset, first grant, single-master hold, priority rotation, reset of ptr, forced release.
    add(1, 8'hFF, 8'h00, 0, 0);
    add(1, 8'hFF, 8'h00, 0, 0);
    add(1, 8'hFF, 8'h00, 0, 0);
    add(0, 8'hFF, 8'h01, 0, 0);
    add(0, 8'h00, 8'h00, 0, 0);
    add(0, 8'h00, 8'h00, 0, 0);
    add(0, 8'h08, 8'h08, 0, 3);
    add(0, 8'h08, 8'h08, 0, 3);
    add(0, 8'h08, 8'h08, 0, 3);
    add(0, 8'h00, 8'h00, 0, 3);
    add(0, 8'h00, 8'h00, 0, 3);
    add(0, 8'h01, 8'h01, 0, 0);
    add(0, 8'h00, 8'h00, 0, 0);
    add(0, 8'h81, 8'h80, 0, 7);
    add(0, 8'h01, 8'h00, 0, 7);
    add(0, 8'h01, 8'h01, 0, 0);
    add(0, 8'h00, 8'h00, 0, 0);
    add(0, 8'h10, 8'h10, 0, 4);
    add(0, 8'h00, 8'h00, 0, 4);
    add(0, 8'h10, 8'h10, 0, 4);
    add(0, 8'h10, 8'h10, 0, 4);
    add(1, 8'h10, 8'h00, 0, 0);
    add(0, 8'h30, 8'h10, 0, 4);
    add(0, 8'h30, 8'h10, 0, 4);
    add(0, 8'h30, 8'h10, 0, 4);
    add(0, 8'h30, 8'h10, 0, 4);
    add(0, 8'h30, 8'h00, 1, 4);
    add(0, 8'h30, 8'h20, 0, 5);
    add(0, 8'h00, 8'h00, 0, 5);
    add(0, 8'h00, 8'h00, 0, 5);

    #1;
    foreach (vecs[k]) begin
      rst = vecs[k].rst; req = vecs[k].req; lock = vecs[k].lock;
      step();
      check_out($sformatf("vec%0d", k), vecs[k].grant, vecs[k].preempt, vecs[k].idx);
    end

    // All masters requesting: 4 grant cycles then a preempt gap, rotating 0..7.
    rst = 1'b1; req = 8'hFF; step();
    check_out("rot_rst", 8'h00, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int c = 1; c <= 40; c++) begin
      int owner, slot;
      step();
      owner = (c - 1) / 5;
      slot  = (c - 1) % 5;
      check_out($sformatf("rot%0d", c), (slot < 4) ? (8'h01 << owner) : 8'h00, slot == 4,
                3'(owner));
      check("rot.onehot0", 32'($onehot0(grant)), 32'd1);
      if (grant_valid) cnt[grant_idx]++;
    end
    for (int i = 0; i < N; i++) check($sformatf("rot.share%0d", i), 32'(cnt[i]), 32'd4);

    // Owner 2 holding with lock while everyone else waits.
    rst = 1'b1; req = 8'h00; step();
    rst = 1'b0; req = 8'h04; step();
    check_out("lock.first", 8'h04, 0, 2);
    req = 8'hFF; lock = 1'b1;
    if (LockEn) begin
      for (int k = 1; k <= 9; k++) begin
        step();
        check_out($sformatf("lock.hold%0d", k), 8'h04, 0, 2);
      end
      lock = 1'b0; step();
      check_out("lock.drop", 8'h00, 1, 2);
    end else begin
      for (int k = 1; k <= 3; k++) begin
        step();
        check_out($sformatf("nolock.hold%0d", k), 8'h04, 0, 2);
      end
      step();
      check_out("nolock.force", 8'h00, 1, 2);
    end
    lock = 1'b0; step();
    check_out("lock.next", 8'h08, 0, 3);

    // Randomized traffic against the reference model; requests persist with rare toggles.
    want = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) want[b] = ~want[b];
      rst  = (c == 0) || ($urandom_range(0, 199) == 0);
      req  = want;
      lock = ($urandom_range(0, 3) == 0);
      model_edge(rst, req, lock);
      step();
      check("rnd.grant", 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      check("rnd.valid", 32'(grant_valid), 32'(m_owner >= 0));
      check("rnd.idx", 32'(grant_idx), 32'(m_last));
      check("rnd.preempt", 32'(preempt), 32'(m_pre));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
